// File: rtl/led_seq_pkg.sv
// Shared types for the LED sequencer.
//   mode_e   : runtime pattern mode, encoded to match the 2-bit mode input
//   dir_e    : bounce travel direction
//   ps_width : prescaler width for a given step period (at least 1 bit)
package led_seq_pkg;

    typedef enum logic [1:0] {
        ROT_L  = 2'd0,
        ROT_R  = 2'd1,
        BOUNCE = 2'd2,
        BLINK  = 2'd3
    } mode_e;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_e;

    function automatic int ps_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/led_pwm.sv
// Free-running PWM brightness gate.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   brightness : requested duty, sampled only at the start of each PWM period
//   gate       : 1 while the LEDs may be lit in the current cycle
module led_pwm #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] brightness,
    output logic                gate
);

    logic [PWM_BITS-1:0] pc;
    logic [PWM_BITS-1:0] br_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc   <= '0;
            br_q <= '0;
        end else begin
            // Latching only at pc=0 keeps every period glitch-free.
            if (pc == '0)
                br_q <= brightness;
            pc <= pc + 1'b1;
        end
    end

    // All-ones must be fully on; a plain compare would leave one dark cycle.
    assign gate = (br_q == '1) | (pc < br_q);

endmodule

// File: rtl/led_sequencer.sv
// Configurable LED pattern generator.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   en         : 1 = prescaler and pattern advance, 0 = hold
//   mode       : 0 ROT_L, 1 ROT_R, 2 BOUNCE, 3 BLINK
//   brightness : PWM duty (all-ones = fully on)
//   led        : LED pins, inverted when ACTIVE_LOW
//   step_pulse : high in the first cycle led shows a new step
//
// Pattern/direction FSM (dir, only meaningful in BOUNCE):
//   state | meaning
//   UP    | lit bit travels toward the MSB
//   DOWN  | lit bit travels toward bit0
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int NUM_LEDS    = 3,
    parameter int STEP_CYCLES = 13_500_000,
    parameter int PWM_BITS    = 8,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [NUM_LEDS-1:0] led,
    output logic                step_pulse
);

    localparam int              PS_W    = ps_width(STEP_CYCLES);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(STEP_CYCLES - 1);

    mode_e               mode_in;
    mode_e               mode_q;
    dir_e                dir;
    dir_e                dir_next;
    logic [NUM_LEDS-1:0] pat;
    logic [NUM_LEDS-1:0] pat_next;
    logic [NUM_LEDS-1:0] led_next;
    logic [PS_W-1:0]     ps;
    logic [PS_W-1:0]     ps_next;
    logic                reload;
    logic                step;
    logic                step_d;
    logic                gate;

    assign mode_in = mode_e'(mode);

    led_pwm #(.PWM_BITS(PWM_BITS)) u_pwm (
        .clk        (clk),
        .rst        (rst),
        .brightness (brightness),
        .gate       (gate)
    );

    // A mode change takes priority over a coincident prescaler wrap.
    always_comb begin
        reload = (mode_in != mode_q);
        step   = !reload && en && (ps == PS_LAST);
        if (reload)
            ps_next = '0;
        else if (en)
            ps_next = (ps == PS_LAST) ? '0 : ps + 1'b1;
        else
            ps_next = ps;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat    <= NUM_LEDS'(1);
            dir    <= UP;
            mode_q <= ROT_L;
            ps     <= '0;
        end else begin
            pat    <= pat_next;
            dir    <= dir_next;
            mode_q <= mode_in;
            ps     <= ps_next;
        end
    end

    always_comb begin
        pat_next = pat;
        dir_next = dir;
        if (reload) begin
            pat_next = (mode_in == BLINK) ? '1 : NUM_LEDS'(1);
            dir_next = UP;
        end else if (step) begin
            case (mode_q)
                // With NUM_LEDS=1 both shift terms collapse to pat itself.
                ROT_L: pat_next = (pat << 1) | (pat >> (NUM_LEDS - 1));
                ROT_R: pat_next = (pat >> 1) | (pat << (NUM_LEDS - 1));
                BOUNCE: begin
                    if (NUM_LEDS > 1) begin
                        if (dir == UP) begin
                            if (pat[NUM_LEDS-1]) begin
                                dir_next = DOWN;
                                pat_next = pat >> 1;
                            end else begin
                                pat_next = pat << 1;
                            end
                        end else begin
                            if (pat[0]) begin
                                dir_next = UP;
                                pat_next = pat << 1;
                            end else begin
                                pat_next = pat >> 1;
                            end
                        end
                    end
                end
                BLINK:   pat_next = ~pat;
                default: pat_next = pat;
            endcase
        end
    end

    always_comb begin
        led_next = (pat & {NUM_LEDS{gate}}) ^ {NUM_LEDS{ACTIVE_LOW}};
    end

    // step_pulse is delayed twice so it lines up with the first led cycle
    // that shows the new pattern (pat updates, then led samples it).
    always_ff @(posedge clk) begin
        if (rst) begin
            led        <= {NUM_LEDS{ACTIVE_LOW}};
            step_d     <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            led        <= led_next;
            step_d     <= step;
            step_pulse <= step_d;
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
module tb_led_sequencer;

    localparam int STEP   = 4;
    localparam int NCYC   = 4000;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] brightness;
    logic [3:0] led_a;
    logic       sp_a;
    logic [2:0] led_b;
    logic       sp_b;

    always #5 clk = ~clk;

    led_sequencer #(
        .NUM_LEDS(4), .STEP_CYCLES(STEP), .PWM_BITS(4), .ACTIVE_LOW(1'b0)
    ) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .brightness(brightness),
        .led(led_a), .step_pulse(sp_a)
    );

    led_sequencer #(
        .NUM_LEDS(3), .STEP_CYCLES(STEP), .PWM_BITS(4), .ACTIVE_LOW(1'b1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .brightness(brightness),
        .led(led_b), .step_pulse(sp_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Reference: the lit LED is tracked as a position index (or an on flag
    // in blink mode), not as a shift register.
    typedef struct {
        int pos;
        bit down;
        bit on;
        int ps;
        int mode_q;
        int pc;
        int brq;
        int led;
        bit sp;
        bit spd;
    } mdl_t;

    function automatic int pat_of(mdl_t s, int n);
        if (s.mode_q == 3)
            return s.on ? (1 << n) - 1 : 0;
        return 1 << s.pos;
    endfunction

    function automatic mdl_t mdl_next(mdl_t s, int n, bit al, bit r, bit e, int m, int b);
        mdl_t t;
        int   dark;
        bit   g;
        bit   stp;
        t    = s;
        dark = al ? (1 << n) - 1 : 0;
        stp  = 1'b0;
        if (r) begin
            t.pos = 0; t.down = 0; t.on = 0; t.ps = 0; t.mode_q = 0;
            t.pc = 0; t.brq = 0; t.led = dark; t.sp = 0; t.spd = 0;
            return t;
        end
        g     = (s.brq == 15) || (s.pc < s.brq);
        t.led = (g ? pat_of(s, n) : 0) ^ dark;
        if (m != s.mode_q) begin
            t.mode_q = m; t.pos = 0; t.down = 0; t.on = 1; t.ps = 0;
        end else if (e) begin
            if (s.ps == STEP - 1) begin
                t.ps = 0;
                stp  = 1'b1;
                case (s.mode_q)
                    0: t.pos = (s.pos + 1) % n;
                    1: t.pos = (s.pos + n - 1) % n;
                    2: if (n > 1) begin
                        if (!s.down) begin
                            if (s.pos == n - 1) begin t.down = 1; t.pos = s.pos - 1; end
                            else t.pos = s.pos + 1;
                        end else begin
                            if (s.pos == 0) begin t.down = 0; t.pos = 1; end
                            else t.pos = s.pos - 1;
                        end
                    end
                    default: t.on = !s.on;
                endcase
            end else begin
                t.ps = s.ps + 1;
            end
        end
        t.sp  = s.spd;
        t.spd = stp;
        if (s.pc == 0)
            t.brq = b;
        t.pc = (s.pc + 1) % 16;
        return t;
    endfunction

    mdl_t ma, mb;
    bit   rst_prev;
    int   duty_cnt;

    initial begin
        rst        = 1'b1;
        en         = 1'b1;
        mode       = 2'd0;
        brightness = 4'hF;
        rst_prev   = 1'b1;
        duty_cnt   = 0;
        ma = mdl_next(ma, 4, 1'b0, 1'b1, en, 0, 15);
        mb = mdl_next(mb, 3, 1'b1, 1'b1, en, 0, 15);

        for (int i = 0; i < NCYC; i++) begin
            @(negedge clk);
            check("led_a", led_a, ma.led);
            check("step_a", sp_a, ma.sp);
            check("led_b", led_b, mb.led);
            check("step_b", sp_b, mb.sp);
            if (rst_prev) begin
                check("rst_dark_a", led_a, 4'b0000);
                check("rst_dark_b", led_b, 3'b111);
                check("rst_step", sp_a, 1'b0);
            end
            if (i >= 175 && i < 191)
                duty_cnt += led_a[0];
            if (i == 191)
                check("duty_br4", duty_cnt, 4);

            // Directed phases first, then random traffic.
            rst = (i < 3);
            if (i < 40)       begin mode = 2'd0; en = 1'b1; brightness = 4'hF; end
            else if (i < 80)  mode = 2'd2;
            else if (i < 110) mode = 2'd1;
            else if (i < 150) begin
                mode = (i < 113) ? 2'd1 : 2'd3;
                en   = !(i >= 125 && i < 132);
            end else if (i < 300) begin
                mode = 2'd0;
                en   = 1'b0;
                if (i < 230)      brightness = 4'd4;
                else if (i < 277) brightness = 4'd0;
                else              brightness = 4'd9;
            end else begin
                if ($urandom % 40 == 0) mode = 2'($urandom_range(3, 0));
                if ($urandom % 15 == 0) en = ~en;
                if ($urandom % 30 == 0) brightness = 4'($urandom_range(15, 0));
                if ($urandom % 25 == 0) brightness = 4'hF;
                rst = ($urandom % 200 == 0);
            end
            rst_prev = rst;

            ma = mdl_next(ma, 4, 1'b0, rst, en, int'(mode), int'(brightness));
            mb = mdl_next(mb, 3, 1'b1, rst, en, int'(mode), int'(brightness));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Parametrised LED pattern generator driving the board's user LEDs from the system clock. It replaces fixed single-pattern rotation with a configurable LED count, step period, and output polarity. Four runtime-selectable modes are supported: rotate left, rotate right, bounce, and blink-all. A PWM brightness gate and a step strobe are provided for other logic. The block sits at top level between the clock input and the LED pins.

## Interface
- NUM_LEDS, 3, number of LEDs driven (≥1)
- STEP_CYCLES, 13_500_000, clock cycles per pattern step (≥2)
- PWM_BITS, 8, brightness resolution
- ACTIVE_LOW, 1, 1 = LED lit when pin low
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- en  in  1  1 = stepping runs; 0 = pattern and prescaler hold
- mode  in  2  0 ROT_L, 1 ROT_R, 2 BOUNCE, 3 BLINK
- brightness  in  PWM_BITS  duty; all-ones = fully on, 0 = off
- led  out  NUM_LEDS  LED pins, polarity per ACTIVE_LOW
- step_pulse  out  1  one-cycle strobe, high in first cycle led shows a new step

## Operation
- The internal pattern `pat[NUM_LEDS-1:0]` is logical active-high. Reset value is bit0 only; dir = UP.
- Prescaler `ps` counts 0..STEP_CYCLES-1 while en=1. At STEP_CYCLES-1 it wraps to 0 and a step occurs.
- Step behaviour by mode:
  - ROT_L: rotate left (MSB→bit0).
  - ROT_R: rotate right.
  - BOUNCE: shift toward MSB while UP. A step taken with MSB lit sets DOWN and shifts right; the mirror applies at bit0. There is no dwell at the ends. N=3 sequence: 001,010,100,010,001,010…
  - BLINK: pat toggles between all-ones and all-zeros.
- Mode change: `mode` is registered as mode_q. When mode ≠ mode_q in a cycle, that edge reloads pat and clears ps. The reload is bit0 with dir UP, or all-ones if the new mode is BLINK. No step occurs that edge.
- NUM_LEDS=1: rotate and bounce hold pat=1. BLINK toggles normally.
- en=0: ps and pat hold. PWM keeps running and led keeps showing pat. A mode change still reloads.
- PWM: a free-running PWM_BITS counter `pc`. `brightness` is latched into br_q when pc=0.
  - gate = (br_q == all-ones) | (pc < br_q).
- Output: led_reg ← (pat & {NUM_LEDS{gate}}) ^ {NUM_LEDS{ACTIVE_LOW}}.
- Reset values: led = all LEDs dark, i.e. all-ones if ACTIVE_LOW else all-zeros. step_pulse=0, ps=0, pc=0, br_q=0, mode_q=ROT_L.

## Timing
- A step fires on the edge where ps=STEP_CYCLES-1 and en=1. pat updates at that edge.
- led reflects pat and gate one cycle later. step_pulse is delayed to coincide with that first led cycle.
- Step period is exactly STEP_CYCLES cycles with en held high. Pausing en extends the period by exactly the paused cycles.
- Brightness changes apply at the next PWM period start. The PWM period is 2^PWM_BITS cycles.
- rst asserted mid-step overrides all, including a coincident step or mode change. After rst deasserts, the first step occurs STEP_CYCLES cycles after the first en=1 cycle.
- A mode change coincident with a prescaler wrap: the reload wins and ps clears. There is no step_pulse for that edge.

## Structure
- Package `led_seq_pkg`:
  - `mode_e` enum {ROT_L, ROT_R, BOUNCE, BLINK}
  - `dir_e` enum {UP, DOWN}
  - helper constant `PS_W = $clog2(STEP_CYCLES)`, computed in module from the parameter
- Sub-module `led_pwm`: holds pc, br_q latch, and gate output, parametrised by PWM_BITS.
- The top holds the prescaler, the pattern/direction FSM, mode_q, and the output registers.

## Test plan
All scenarios use NUM_LEDS=4, STEP_CYCLES=4, PWM_BITS=4, ACTIVE_LOW=0, brightness=4'hF unless stated.
- Reset/ROT_L, en=1: led=0000 during rst. After release, led=0001, then 0010, 0100, 1000, 0001 at 4-cycle spacing. step_pulse is high in each change cycle.
- BOUNCE: sequence 0001,0010,0100,1000,0100,0010,0001,0010. Endpoints show no repeated value.
- Mode switch ROT_R→BLINK mid-step: next cycle pat reloads to 1111 and ps=0. led=1111 then toggles 0000 four cycles later. No step_pulse at the switch.
- en low for 7 cycles between steps: led holds. The next step arrives at 4+7 cycles after the previous one.
- PWM: brightness=4 with led bit lit gives 4 of every 16 cycles high. brightness=0 gives constant low. A change mid-period takes effect only at pc=0.
- ACTIVE_LOW=1, NUM_LEDS=3, default STEP_CYCLES scaled to 4: reset gives led=111, then 110, 101, 011. rst asserted during a step edge gives led=111 the following cycle.
